// File: rtl/carregador_ram.sv
// ============================================================================
// carregador_ram
// ----------------------------------------------------------------------------
// Front-end for the 16x8 SAP-1 RAM. It owns the 4-bit memory address register
// and the manual programming path.
//
//   Program mode (programm_run = 0)
//     The raw write push-button is synchronized and debounced. Each accepted
//     press latches the data switches and produces exactly one registered,
//     single-cycle write strobe. The address comes either straight from the
//     address switches or from an auto-incrementing counter.
//
//   Run mode (programm_run = 1)
//     The block behaves as the plain MAR: it loads bus_in[3:0] when MAR_IN is
//     high and otherwise holds. The button is ignored and any in-flight
//     programming sequence is dropped.
//
// Ports
//   clock         system clock, all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   programm_run  1 = run mode, 0 = program mode
//   MAR_IN        run mode: load out_mar from bus_in[3:0]
//   bus_in        W-bus, only [3:0] is used
//   addr_dip      address switches
//   data_dip      data switches
//   WR_BUTTON     raw bouncing push-button, 1 = pressed
//   auto_inc      1 = out_mar advances after each manual write
//   out_mar       address to the RAM
//   ram_dip       latched write data to the RAM
//   WR_PULSE      single-cycle write strobe to the RAM
//   busy          1 whenever the FSM is outside IDLE
// ============================================================================
module carregador_ram #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       programm_run,
    input  logic       MAR_IN,
    input  logic [7:0] bus_in,
    input  logic [3:0] addr_dip,
    input  logic [7:0] data_dip,
    input  logic       WR_BUTTON,
    input  logic       auto_inc,
    output logic [3:0] out_mar,
    output logic [7:0] ram_dip,
    output logic       WR_PULSE,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        SETUP,
        WRITE,
        WAIT_REL,
        DEB_REL
    } state_t;

    // The debounce counter is compared against the value it holds on the
    // edge that brings it to DEBOUNCE_CYCLES, so the terminal value is one
    // less than the required stable count.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;
    logic             auto_inc_q;

    // Only the low nibble of the bus addresses the 16-word RAM.
    logic             unused_bus;
    assign unused_bus = ^bus_in[7:4];

    // ------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous push-button. Everything
    // downstream looks at s2 only.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= WR_BUTTON;
            s2 <= s1;
        end
    end

    // ------------------------------------------------------------------------
    // History of auto_inc, used to spot the 0->1 edge that seeds the address
    // counter from the switches.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_inc_q <= 1'b0;
        end else begin
            auto_inc_q <= auto_inc;
        end
    end

    // ------------------------------------------------------------------------
    // Programming FSM with registered outputs.
    //
    // A press must be stable for DEBOUNCE_CYCLES synchronized cycles before it
    // is accepted; the data switches are captured on the accepting edge. SETUP
    // gives the RAM one quiet cycle with address and data settled, WRITE is
    // the strobe cycle, and the release must then be stable for the same
    // number of cycles before another press can be seen. Holding the button
    // simply parks the FSM in WAIT_REL, so a long press yields one strobe.
    //
    // busy and WR_PULSE are driven from the transition itself, which keeps
    // them glitch-free flop outputs that track the state register exactly.
    //
    // Run mode overrides everything and returns to IDLE on the next edge;
    // this also covers the case of run mode arriving on the edge that would
    // have entered WRITE, so no strobe escapes.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ram_dip  <= 8'h00;
            WR_PULSE <= 1'b0;
            busy     <= 1'b0;
        end else if (programm_run) begin
            state    <= IDLE;
            cnt      <= '0;
            WR_PULSE <= 1'b0;
            busy     <= 1'b0;
        end else begin
            WR_PULSE <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= DEB_PRESS;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                DEB_PRESS: begin
                    if (!s2) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= SETUP;
                        cnt     <= '0;
                        ram_dip <= data_dip;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SETUP: begin
                    state    <= WRITE;
                    WR_PULSE <= 1'b1;
                end

                WRITE: begin
                    state <= WAIT_REL;
                end

                WAIT_REL: begin
                    if (!s2) begin
                        state <= DEB_REL;
                        cnt   <= '0;
                    end
                end

                DEB_REL: begin
                    if (s2) begin
                        state <= WAIT_REL;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Memory address register.
    //
    // Run mode: classic MAR, load from the bus on MAR_IN.
    // Program mode, auto_inc=0: follow the address switches while IDLE and
    //   freeze during a write sequence so the switches cannot move the
    //   address under an in-progress strobe.
    // Program mode, auto_inc=1: the register becomes a counter seeded from
    //   the switches on the rising edge of auto_inc and advanced (mod 16) as
    //   the FSM leaves WRITE. The seed wins if both happen on the same edge.
    //   Coming back from run mode the counter keeps whatever the MAR held.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_mar <= 4'h0;
        end else if (programm_run) begin
            if (MAR_IN) begin
                out_mar <= bus_in[3:0];
            end
        end else if (auto_inc) begin
            if (!auto_inc_q) begin
                out_mar <= addr_dip;
            end else if (state == WRITE) begin
                out_mar <= out_mar + 4'd1;
            end
        end else if (state == IDLE) begin
            out_mar <= addr_dip;
        end
    end

endmodule

// File: doc/carregador_ram.md
Name: carregador_ram

Overview:
- Upstream front-end of the 16x8 SAP-1 RAM. Owns the 4-bit memory address register and the manual programming path.
- Program mode (programm_run=0): debounces the raw write push-button and latches the data DIP switches. Emits exactly one clean single-cycle write strobe per press, with optional address auto-increment.
- Run mode (programm_run=1): acts as the MAR and loads the address from the bus.
- Outputs drive the RAM's address input (in_mar), data DIP input (ram_dip) and WR_BUTTON input directly.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronized clock cycles of stable level required to accept a press or a release (legal values >= 2).
- CNT_W, 5, width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- programm_run  in  1  1 = run mode, 0 = program mode.
- MAR_IN  in  1  run mode: load out_mar from bus_in[3:0] on the next edge.
- bus_in  in  8  W-bus; only bits [3:0] are used.
- addr_dip  in  4  address switches.
- data_dip  in  8  data switches.
- WR_BUTTON  in  1  raw, asynchronous, bouncing push-button (1 = pressed).
- auto_inc  in  1  1 = out_mar increments after each manual write.
- out_mar  out  4  address to RAM (in_mar).
- ram_dip  out  8  latched write data to RAM.
- WR_PULSE  out  1  single-cycle write strobe to RAM (its WR_BUTTON/WE path).
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset values (while reset_n=0, applied asynchronously):
  - out_mar=0, ram_dip=0, WR_PULSE=0, busy=0.
  - FSM=IDLE, debounce counter=0, both synchronizer flops=0, auto_inc history flop=0.
- Button synchronizer:
  - WR_BUTTON passes through a 2-flop synchronizer; s2 is the synchronized level.
  - The FSM sees only s2.
- FSM states: IDLE, DEB_PRESS, SETUP, WRITE, WAIT_REL, DEB_REL.
  - IDLE: s2=1 -> DEB_PRESS with counter=0.
  - DEB_PRESS: s2=0 -> IDLE with counter cleared (bounce rejected). Otherwise the counter increments; on the edge where it reaches DEBOUNCE_CYCLES -> SETUP, and ram_dip latches data_dip on that same edge.
  - SETUP: one cycle; out_mar and ram_dip are stable. Next edge -> WRITE.
  - WRITE: WR_PULSE=1 for exactly this one cycle. Next edge -> WAIT_REL; if auto_inc=1, out_mar increments on that same edge.
  - WAIT_REL: s2=0 -> DEB_REL with counter=0.
  - DEB_REL: s2=1 -> WAIT_REL. After DEBOUNCE_CYCLES consecutive edges with s2=0 -> IDLE.
- Timing and strobe rules:
  - Latency: the first edge that samples WR_BUTTON=1 is edge 0. With no bounce, WR_PULSE is high for the cycle between edges 3+DEBOUNCE_CYCLES and 4+DEBOUNCE_CYCLES (edge 19 to edge 20 at default).
  - WR_PULSE is registered and glitch-free.
  - One press yields exactly one pulse, regardless of hold time.
- Address in program mode:
  - auto_inc=0: out_mar <= addr_dip on every edge while FSM=IDLE; held in all other states.
  - auto_inc=1: out_mar is a counter. On the edge where auto_inc is sampled 0->1, it loads from addr_dip. Otherwise it changes only on the WRITE-exit increment.
  - Increment wraps modulo 16 (15 -> 0).
- Run mode (programm_run=1):
  - FSM is forced to IDLE on the next edge (any in-flight sequence is aborted); WR_PULSE=0 and the button is ignored.
  - MAR_IN=1 -> out_mar <= bus_in[3:0]; otherwise out_mar is held.
  - ram_dip is held.
- MAR_IN is ignored in program mode.
- Simultaneous events:
  - If programm_run rises on the edge that would enter WRITE, no pulse is issued.
  - A reset in any state returns to reset values immediately, with no pulse issued.
- Switching run -> program resumes the IDLE address rules. The auto_inc counter keeps the current out_mar until the next 0->1 edge of auto_inc.

Test Plan:
- Reset mid-DEB_PRESS: assert reset_n=0 -> all outputs 0, FSM=IDLE. Release and hold WR_BUTTON high -> exactly one WR_PULSE, no residue from the interrupted press.
- Clean press, program mode: addr_dip=5, data_dip=8'hA3, auto_inc=0, WR_BUTTON held high for 40 cycles -> single WR_PULSE at edge 19 with out_mar=5 and ram_dip=A3. busy returns to 0 only after 16 cycles of release.
- Bounce rejection: WR_BUTTON toggles every 5 cycles for 60 cycles, then stays low -> no WR_PULSE, busy returns to 0.
- Auto-increment wrap: auto_inc 0->1 with addr_dip=14, then three clean presses with data 11,22,33 -> writes at addresses 14, 15, 0; out_mar ends at 1.
- Run mode MAR: programm_run=1, bus_in=8'hF7, MAR_IN pulse -> out_mar=7 on the next edge. A WR_BUTTON press produces no WR_PULSE.
- Mode switch mid-sequence: programm_run rises while FSM=SETUP -> no WR_PULSE, busy=0 on the next edge.
